// File: rtl/alu4_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu4_arbiter_pkg
// Purpose  : Opcodes, FSM state encoding and helpers shared by the alu4 arbiter.
// Revision : 1.0  initial release
// ============================================================================
package alu4_arbiter_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_NOT = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_LT  = 3'd6;
    localparam logic [2:0] OP_EQ  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu4_arbiter_alu4.sv
`default_nettype none
// ============================================================================
// Module   : alu4
// Purpose  : 4-bit combinational ALU; compares are unsigned and return 1/0.
// Revision : 1.0  initial release
// ============================================================================
module alu4
    import alu4_arbiter_pkg::*;
(
    input  logic [2:0] op_i,
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [3:0] y_o
);

    always_comb begin
        y_o = 4'h0;
        unique case (op_i)
            OP_ADD:  y_o = a_i + b_i;
            OP_SUB:  y_o = a_i - b_i;
            OP_NOT:  y_o = ~a_i;
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_LT:   y_o = {3'b000, (a_i < b_i)};
            OP_EQ:   y_o = {3'b000, (a_i == b_i)};
            default: y_o = 4'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu4_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick: first set request at or after ptr.
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    int            w_j;
    logic [IW-1:0] w_sel;
    logic          w_found;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        w_j     = 0;
        w_sel   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            // Walk candidates in priority order, wrapping past N-1 back to 0.
            w_j = int'(ptr_i) + k;
            if (w_j >= N) begin
                w_j = w_j - N;
            end
            w_sel = IW'(w_j);
            if (!w_found && req_i[w_sel]) begin
                w_found      = 1'b1;
                gnt_o[w_sel] = 1'b1;
                idx_o        = w_sel;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu4_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu4_arbiter
// Purpose  : Shares one alu4 between NREQ requesters with round-robin grants.
// Revision : 1.0  initial release
// ============================================================================
module alu4_arbiter
    import alu4_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [3*NREQ-1:0] req_op,
    input  logic [4*NREQ-1:0] req_a,
    input  logic [4*NREQ-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [3:0]        rsp_data,
    output logic [IDW-1:0]    rsp_id,
    output logic              busy
);

    state_e           state_q,     state_d;
    logic [IDW-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [2:0]       op_q,        op_d;
    logic [3:0]       a_q,         a_d;
    logic [3:0]       b_q,         b_d;
    logic [IDW-1:0]   id_q,        id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [3:0]       rsp_data_q,  rsp_data_d;
    logic [IDW-1:0]   rsp_id_q,    rsp_id_d;

    logic [NREQ-1:0]  w_gnt;
    logic [IDW-1:0]   w_gnt_idx;
    logic [3:0]       w_alu_y;
    logic [2:0]       w_op [NREQ];
    logic [3:0]       w_a  [NREQ];
    logic [3:0]       w_b  [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign w_op[i] = req_op[3*i +: 3];
        assign w_a[i]  = req_a[4*i +: 4];
        assign w_b[i]  = req_b[4*i +: 4];
    end

    rr_arbiter #(
        .N  (NREQ),
        .IW (IDW)
    ) u_rr (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (w_gnt),
        .idx_o (w_gnt_idx)
    );

    alu4 u_alu (
        .op_i (op_q),
        .a_i  (a_q),
        .b_i  (b_q),
        .y_o  (w_alu_y)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        req_ready   = '0;
        unique case (state_q)
            ST_IDLE: begin
                req_ready = w_gnt;
                if (|req_valid) begin
                    op_d     = w_op[w_gnt_idx];
                    a_d      = w_a[w_gnt_idx];
                    b_d      = w_b[w_gnt_idx];
                    id_d     = w_gnt_idx;
                    rr_ptr_d = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d  = w_alu_y;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset clears everything, so an op in flight never produces a response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu4_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu4_arbiter
// Purpose  : Directed self-checking bench for alu4_arbiter (NREQ=2 and NREQ=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_alu4_arbiter;
    import alu4_arbiter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        rsp_ready;

    logic [1:0]  req_valid, req_ready;
    logic [5:0]  req_op;
    logic [7:0]  req_a, req_b;
    logic        rsp_valid, busy;
    logic [3:0]  rsp_data;
    logic [0:0]  rsp_id;

    logic [3:0]  v4, rdy4;
    logic [11:0] op4;
    logic [15:0] a4, b4;
    logic        rv4, busy4;
    logic [3:0]  rd4;
    logic [1:0]  rid4;

    int vectors = 0;
    int errors  = 0;

    // Scoreboards hold {id, data} of each accepted op.
    logic [5:0] sb  [$];
    logic [5:0] sb4 [$];

    alu4_arbiter #(.NREQ(2), .IDW(1)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    alu4_arbiter #(.NREQ(4), .IDW(2)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (v4),
        .req_ready (rdy4),
        .req_op    (op4),
        .req_a     (a4),
        .req_b     (b4),
        .rsp_valid (rv4),
        .rsp_ready (rsp_ready),
        .rsp_data  (rd4),
        .rsp_id    (rid4),
        .busy      (busy4)
    );

    function automatic logic [3:0] ref_alu(input logic [2:0] op, input logic [3:0] a,
                                           input logic [3:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_NOT:  return ~a;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_LT:   return (a < b) ? 4'h1 : 4'h0;
            default: return (a == b) ? 4'h1 : 4'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        sb.delete();
        sb4.delete();
    endtask

    task automatic set_fields2(input int i, input logic [2:0] op, input logic [3:0] a,
                               input logic [3:0] b);
        req_op[3*i +: 3] = op;
        req_a[4*i +: 4]  = a;
        req_b[4*i +: 4]  = b;
    endtask

    task automatic rsp_check2(input string tag);
        logic [5:0] e;
        chk($sformatf("%s_sb_pending", tag), 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("%s_data", tag), 32'(rsp_data), 32'(e[3:0]));
            chk($sformatf("%s_id", tag), 32'(rsp_id), 32'(e[5:4]));
        end
    endtask

    // One full transaction on the 2-requester DUT, starting from IDLE.
    task automatic run2(input logic [1:0] vmask, input int exp_idx, input logic hold,
                        input string tag);
        req_valid = vmask;
        #1;
        chk($sformatf("%s_gnt", tag), 32'(req_ready), 32'(1 << exp_idx));
        sb.push_back({2'(exp_idx), ref_alu(req_op[3*exp_idx +: 3], req_a[4*exp_idx +: 4],
                                           req_b[4*exp_idx +: 4])});
        tick();
        if (!hold) req_valid = '0;
        #1;
        chk($sformatf("%s_exec_ready", tag), 32'(req_ready), 32'd0);
        chk($sformatf("%s_exec_nrsp", tag), 32'(rsp_valid), 32'd0);
        tick();
        chk($sformatf("%s_rsp_valid", tag), 32'(rsp_valid), 32'd1);
        rsp_check2(tag);
        tick();
        chk($sformatf("%s_back_idle", tag), 32'({busy, rsp_valid}), 32'd0);
    endtask

    task automatic run4(input logic [3:0] vmask, input int exp_idx, input string tag);
        logic [5:0] e;
        v4 = vmask;
        #1;
        chk($sformatf("%s_gnt", tag), 32'(rdy4), 32'(1 << exp_idx));
        sb4.push_back({2'(exp_idx), ref_alu(op4[3*exp_idx +: 3], a4[4*exp_idx +: 4],
                                            b4[4*exp_idx +: 4])});
        tick();
        v4 = '0;
        chk($sformatf("%s_busy", tag), 32'(busy4), 32'd1);
        tick();
        chk($sformatf("%s_rsp_valid", tag), 32'(rv4), 32'd1);
        e = sb4.pop_front();
        chk($sformatf("%s_data", tag), 32'(rd4), 32'(e[3:0]));
        chk($sformatf("%s_id", tag), 32'(rid4), 32'(e[5:4]));
        tick();
        chk($sformatf("%s_idle", tag), 32'(busy4), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        v4        = '0;
        op4       = '0;
        a4        = '0;
        b4        = '0;

        do_reset();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);

        // ADD 7+9 wraps to 0
        set_fields2(0, OP_ADD, 4'd7, 4'd9);
        run2(2'b01, 0, 1'b0, "t1");

        // Both requesters held valid: grants alternate from rr_ptr=0
        do_reset();
        set_fields2(0, OP_ADD, 4'd1, 4'd2);
        set_fields2(1, OP_XOR, 4'd5, 4'd3);
        for (int k = 0; k < 4; k++) begin
            run2(2'b11, k % 2, 1'b1, $sformatf("t2_%0d", k));
        end
        req_valid = '0;

        // Consumer stall: response held, no new grant while stalled
        rsp_ready = 1'b0;
        set_fields2(1, OP_SUB, 4'd2, 4'd5);
        set_fields2(0, OP_ADD, 4'd8, 4'd8);
        req_valid = 2'b10;
        #1;
        chk("t3_gnt", 32'(req_ready), 32'b10);
        sb.push_back({2'd1, 4'hD});
        tick();
        req_valid = 2'b01;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t3_hold_valid_%0d", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("t3_hold_data_%0d", k), 32'(rsp_data), 32'hD);
            chk($sformatf("t3_hold_ready_%0d", k), 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("t3_release_ready", 32'(req_ready), 32'd0);
        rsp_check2("t3");
        tick();
        run2(2'b01, 0, 1'b0, "t3_next");

        // Op coverage
        set_fields2(0, OP_LT, 4'd3, 4'd12);
        run2(2'b01, 0, 1'b0, "t4_lt");
        set_fields2(0, OP_EQ, 4'd6, 4'd6);
        run2(2'b01, 0, 1'b0, "t4_eq");
        set_fields2(1, OP_NOT, 4'd5, 4'd0);
        run2(2'b10, 1, 1'b0, "t4_not");
        set_fields2(0, OP_XOR, 4'hF, 4'h3);
        run2(2'b01, 0, 1'b0, "t4_xor");
        set_fields2(1, OP_AND, 4'hC, 4'hA);
        run2(2'b10, 1, 1'b0, "t4_and");
        set_fields2(0, OP_OR, 4'h9, 4'h4);
        run2(2'b01, 0, 1'b0, "t4_or");
        set_fields2(1, OP_LT, 4'd9, 4'd2);
        run2(2'b10, 1, 1'b0, "t4_lt_false");

        // Reset while in EXEC drops the op and the pointer
        set_fields2(0, OP_AND, 4'hC, 4'hA);
        req_valid = 2'b01;
        tick();
        req_valid = '0;
        chk("t5_exec_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t5_rsp_data", 32'(rsp_data), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t5_no_stale_%0d", k), 32'(rsp_valid), 32'd0);
        end
        set_fields2(1, OP_ADD, 4'd1, 4'd1);
        run2(2'b11, 0, 1'b0, "t5_ptr0");

        // Four requesters: wrap from req3 back to 0
        op4[2:0]   = OP_ADD; a4[3:0]   = 4'd3; b4[3:0]   = 4'd4;
        op4[11:9]  = OP_OR;  a4[15:12] = 4'd5; b4[15:12] = 4'hA;
        run4(4'b0001, 0, "t6_first");
        run4(4'b1000, 3, "t6_req3");
        op4[2:0]   = OP_SUB; a4[3:0]   = 4'd0; b4[3:0]   = 4'd1;
        run4(4'b1001, 0, "t6_wrap");

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
